// File: rtl/load_store_unit.sv
// load_store_unit: memory stage that follows the ALU. Runs one RV32I load or
// store at a time over a req/ack data-memory port and returns the extended
// load value to writeback.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   valid_in / ready_out      op handshake from execute (ready only in IDLE)
//   is_store, funct3          op type and RV32I width code
//   alu_result                effective address
//   store_data                rs2 value for stores
//   rd_in                     destination register for loads
//   mem_req/mem_we/mem_addr   bus request, write enable, word address
//   mem_wdata/mem_be          lane-replicated store data, byte enables
//   mem_ack/mem_rdata         bus completion and read word (same cycle)
//   wb_valid/wb_rd/wb_data    load writeback pulse, register, value
//   store_done                store completion pulse
//   misaligned/illegal        reject pulses
//
// state | meaning
// IDLE  | ready for a new op; rejects are flagged from here
// BUS   | request on the bus, waiting for mem_ack
// DONE  | completion pulse cycle, then back to IDLE
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        store_done,
  output logic        misaligned,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [4:0]  rd_q;
  logic [2:0]  f3_q;
  logic        st_q;

  logic        legal_in;
  logic        misal_in;
  logic [31:0] wdata_steer;
  logic [3:0]  be_steer;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Decode of the incoming op, used only for the accept/reject decision.
  always_comb begin
    legal_in = 1'b0;
    misal_in = 1'b0;
    if (is_store)
      legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b01:   misal_in = alu_result[0];
      2'b10:   misal_in = |alu_result[1:0];
      default: misal_in = 1'b0;
    endcase
  end

  // Store steering and load extraction work off the latched op so the bus
  // outputs never depend on live inputs.
  always_comb begin
    wdata_steer = data_q;
    be_steer    = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        wdata_steer = {4{data_q[7:0]}};
        be_steer    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wdata_steer = {2{data_q[15:0]}};
        be_steer    = 4'b0011 << addr_q[1:0];
      end
      default: begin
        wdata_steer = data_q;
        be_steer    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = f3_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  assign ready_out = (state == IDLE);
  assign mem_req   = (state == BUS);
  assign mem_we    = st_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_steer;
  assign mem_be    = st_q ? be_steer : 4'b0000;
  assign wb_rd     = rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      st_q       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      store_done <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      store_done <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            // An illegal code takes priority over a misaligned address.
            if (!legal_in) begin
              illegal <= 1'b1;
            end else if (misal_in) begin
              misaligned <= 1'b1;
            end else begin
              addr_q <= alu_result;
              data_q <= store_data;
              rd_q   <= rd_in;
              f3_q   <= funct3;
              st_q   <= is_store;
              state  <= BUS;
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            if (st_q) begin
              store_done <= 1'b1;
            end else begin
              wb_valid <= 1'b1;
              wb_data  <= load_ext;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
